// File: rtl/game_state_ctrl_pkg.sv
// Shared Frogger game definitions: state encodings and geometry constants
// used by the game controller, renderer and car movers.
package game_state_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLAYING   = 3'd1,
    ST_DYING     = 3'd2,
    ST_LEVEL_UP  = 3'd3,
    ST_GAME_OVER = 3'd4
  } game_state_e;

  localparam int TILE_SIZE    = 32;
  localparam int LEVEL_W      = 4;
  localparam int GUARD_CYCLES = 2;

endpackage

// File: rtl/game_state_ctrl_bcd_counter_2d.sv
// Two-digit BCD up-counter {tens,ones}; clear has priority, saturates at 99.
module bcd_counter_2d (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] bcd
);

  logic [7:0] bcd_q, bcd_d;

  always_comb begin
    bcd_d = bcd_q;
    if (clr) begin
      bcd_d = 8'h00;
    end else if (inc && (bcd_q != 8'h99)) begin
      if (bcd_q[3:0] == 4'd9) begin
        bcd_d[3:0] = 4'd0;
        bcd_d[7:4] = bcd_q[7:4] + 4'd1;
      end else begin
        bcd_d[3:0] = bcd_q[3:0] + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) bcd_q <= 8'h00;
    else       bcd_q <= bcd_d;
  end

  assign bcd = bcd_q;

endmodule

// File: rtl/game_state_ctrl.sv
// Frogger game flow: lives, level, score and freeze/respawn sequencing
// driven by collision results from the collision stage.
module game_state_ctrl
  import game_state_ctrl_pkg::*;
#(
  parameter int LIVES_INIT   = 3,
  parameter int MAX_LEVEL    = 9,
  parameter int DEATH_FRAMES = 60,
  parameter int WIN_FRAMES   = 30
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               start_btn,
  input  logic               death_collision,
  input  logic               win_collision,
  output logic [2:0]         game_state,
  output logic [1:0]         lives,
  output logic [LEVEL_W-1:0] level,
  output logic [7:0]         score_bcd,
  output logic               frog_respawn,
  output logic               freeze
);

  localparam int CNT_MAX = (DEATH_FRAMES > WIN_FRAMES) ? DEATH_FRAMES : WIN_FRAMES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  game_state_e        state_q, state_d;
  logic [1:0]         lives_q, lives_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         guard_q, guard_d;
  logic               respawn_q, respawn_d;
  logic               freeze_q, freeze_d;
  logic               score_clr, score_inc;

  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    level_d   = level_q;
    cnt_d     = cnt_q;
    guard_d   = guard_q;
    respawn_d = 1'b0;
    score_clr = 1'b0;
    score_inc = 1'b0;

    case (state_q)
      ST_IDLE, ST_GAME_OVER: begin
        if (start_btn) begin
          state_d   = ST_PLAYING;
          lives_d   = 2'(LIVES_INIT);
          level_d   = LEVEL_W'(1);
          score_clr = 1'b1;
          respawn_d = 1'b1;
          guard_d   = 2'(GUARD_CYCLES);
        end
      end
      ST_PLAYING: begin
        // Frog position is still settling right after a respawn.
        if (guard_q != 2'd0) begin
          guard_d = guard_q - 2'd1;
        end else if (death_collision) begin
          if (lives_q == 2'd1) begin
            lives_d = 2'd0;
            state_d = ST_GAME_OVER;
          end else begin
            lives_d = lives_q - 2'd1;
            state_d = ST_DYING;
            cnt_d   = '0;
          end
        end else if (win_collision) begin
          score_inc = 1'b1;
          if (level_q < LEVEL_W'(MAX_LEVEL)) level_d = level_q + LEVEL_W'(1);
          state_d = ST_LEVEL_UP;
          cnt_d   = '0;
        end
      end
      ST_DYING, ST_LEVEL_UP: begin
        if (frame_tick) begin
          if (cnt_q == ((state_q == ST_DYING) ? CNT_W'(DEATH_FRAMES - 1)
                                              : CNT_W'(WIN_FRAMES - 1))) begin
            state_d   = ST_PLAYING;
            respawn_d = 1'b1;
            guard_d   = 2'(GUARD_CYCLES);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    freeze_d = (state_d != ST_PLAYING);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      lives_q   <= 2'(LIVES_INIT);
      level_q   <= LEVEL_W'(1);
      cnt_q     <= '0;
      guard_q   <= 2'd0;
      respawn_q <= 1'b0;
      freeze_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      lives_q   <= lives_d;
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      guard_q   <= guard_d;
      respawn_q <= respawn_d;
      freeze_q  <= freeze_d;
    end
  end

  bcd_counter_2d u_score (
    .clk   (clk),
    .reset (reset),
    .clr   (score_clr),
    .inc   (score_inc),
    .bcd   (score_bcd)
  );

  assign game_state   = state_q;
  assign lives        = lives_q;
  assign level        = level_q;
  assign frog_respawn = respawn_q;
  assign freeze       = freeze_q;

endmodule
